// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_stage
// Brief    : IF/ID boundary register with one-entry skid and flush squashing.
// Revision : 1.0
// ============================================================================
module fetch_decode_stage #(
    parameter int          XLEN          = 32,
    parameter logic [31:0] NOP           = 32'h00000013,
    parameter int          SQUASH_CYCLES = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            stall,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [31:0]     fetch_instruction,
    output logic            fetch_ready,
    output logic            decode_valid,
    output logic [XLEN-1:0] decode_pc,
    output logic [31:0]     decode_instruction,
    output logic            squashing
);

    localparam logic [1:0] c_squash_load = SQUASH_CYCLES[1:0];

    logic            r_dec_valid;
    logic [XLEN-1:0] r_dec_pc;
    logic [31:0]     r_dec_instr;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_pc;
    logic [31:0]     r_skid_instr;
    logic [1:0]      r_squash_cnt;

    logic w_accept;
    logic w_keep;

    assign w_accept = fetch_valid && !r_skid_valid;
    // Beats accepted while the squash window is open are consumed but dropped.
    assign w_keep   = w_accept && (r_squash_cnt == 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dec_valid  <= 1'b0;
            r_dec_pc     <= '0;
            r_dec_instr  <= NOP;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP;
            r_squash_cnt <= 2'd0;
        end else if (flush) begin
            r_dec_valid  <= 1'b0;
            r_dec_pc     <= '0;
            r_dec_instr  <= NOP;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP;
            r_squash_cnt <= c_squash_load;
        end else begin
            if (r_squash_cnt != 2'd0) begin
                r_squash_cnt <= r_squash_cnt - 2'd1;
            end
            if (stall) begin
                if (w_keep) begin
                    r_skid_valid <= 1'b1;
                    r_skid_pc    <= fetch_pc;
                    r_skid_instr <= fetch_instruction;
                end
            end else if (r_skid_valid) begin
                r_dec_valid  <= 1'b1;
                r_dec_pc     <= r_skid_pc;
                r_dec_instr  <= r_skid_instr;
                r_skid_valid <= 1'b0;
                r_skid_pc    <= '0;
                r_skid_instr <= NOP;
            end else if (w_keep) begin
                r_dec_valid  <= 1'b1;
                r_dec_pc     <= fetch_pc;
                r_dec_instr  <= fetch_instruction;
            end else begin
                r_dec_valid  <= 1'b0;
                r_dec_pc     <= '0;
                r_dec_instr  <= NOP;
            end
        end
    end

    assign fetch_ready        = !r_skid_valid;
    assign decode_valid       = r_dec_valid;
    assign decode_pc          = r_dec_pc;
    assign decode_instruction = r_dec_instr;
    assign squashing          = (r_squash_cnt != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_stage
// Brief    : Directed self-checking bench for fetch_decode_stage.
// Revision : 1.0
// ============================================================================
module tb_fetch_decode_stage;

    localparam logic [31:0] c_nop = 32'h00000013;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        stall;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instruction;
    logic        fetch_ready;
    logic        decode_valid;
    logic [31:0] decode_pc;
    logic [31:0] decode_instruction;
    logic        squashing;

    int compared   = 0;
    int mismatched = 0;

    fetch_decode_stage #(
        .XLEN         (32),
        .NOP          (c_nop),
        .SQUASH_CYCLES(1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .stall             (stall),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_instruction (fetch_instruction),
        .fetch_ready       (fetch_ready),
        .decode_valid      (decode_valid),
        .decode_pc         (decode_pc),
        .decode_instruction(decode_instruction),
        .squashing         (squashing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_decode(input string tag, input logic v, input logic [31:0] pc,
                                input logic [31:0] instr);
        check({tag, ".valid"}, {31'd0, decode_valid}, {31'd0, v});
        check({tag, ".pc"},    decode_pc, pc);
        check({tag, ".instr"}, decode_instruction, instr);
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        fetch_valid       = v;
        fetch_pc          = pc;
        fetch_instruction = instr;
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        offer(1'b1, 32'h40, 32'hDEADBEEF);

        // Reset held two cycles with a live fetch beat
        step();
        step();
        reset = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check_decode("reset", 1'b0, 32'h0, c_nop);
        check("reset.ready", {31'd0, fetch_ready}, 32'd1);
        check("reset.squash", {31'd0, squashing}, 32'd0);
        step();
        check_decode("post_reset", 1'b0, 32'h0, c_nop);

        // Streaming
        offer(1'b1, 32'h0, 32'h00500093); step();
        check_decode("stream0", 1'b1, 32'h0, 32'h00500093);
        offer(1'b1, 32'h4, 32'h00108113); step();
        check_decode("stream1", 1'b1, 32'h4, 32'h00108113);
        offer(1'b1, 32'h8, 32'h002081b3); step();
        check_decode("stream2", 1'b1, 32'h8, 32'h002081b3);
        offer(1'b0, 32'h0, 32'h0); step();
        check_decode("bubble", 1'b0, 32'h0, c_nop);

        // Stall with skid capture
        offer(1'b1, 32'h4, 32'h00108113); step();
        check_decode("stall_pre", 1'b1, 32'h4, 32'h00108113);
        stall = 1'b1;
        offer(1'b1, 32'h8, 32'h002081b3); step();
        check_decode("stall1", 1'b1, 32'h4, 32'h00108113);
        check("stall1.ready", {31'd0, fetch_ready}, 32'd0);
        offer(1'b1, 32'hC, 32'h00310233); step();
        check_decode("stall2", 1'b1, 32'h4, 32'h00108113);
        check("stall2.ready", {31'd0, fetch_ready}, 32'd0);
        step();
        check_decode("stall3", 1'b1, 32'h4, 32'h00108113);
        stall = 1'b0; step();
        check_decode("unstall_skid", 1'b1, 32'h8, 32'h002081b3);
        check("unstall.ready", {31'd0, fetch_ready}, 32'd1);
        step();
        check_decode("unstall_fetch", 1'b1, 32'hC, 32'h00310233);
        offer(1'b0, 32'h0, 32'h0); step();
        check_decode("unstall_idle", 1'b0, 32'h0, c_nop);

        // Flush with one squash cycle
        offer(1'b1, 32'h10, 32'h11111111); step();
        check_decode("flush_pre", 1'b1, 32'h10, 32'h11111111);
        flush = 1'b1;
        offer(1'b1, 32'h14, 32'h22222222); step();
        check_decode("flushN", 1'b0, 32'h0, c_nop);
        check("flushN.squash", {31'd0, squashing}, 32'd1);
        flush = 1'b0;
        offer(1'b1, 32'h18, 32'h33333333); step();
        check_decode("flushN1", 1'b0, 32'h0, c_nop);
        check("flushN1.squash", {31'd0, squashing}, 32'd0);
        offer(1'b1, 32'h100, 32'h44444444); step();
        check_decode("flush_target", 1'b1, 32'h100, 32'h44444444);

        // Flush and stall together with a full skid
        offer(1'b1, 32'h200, 32'h55555555); step();
        check_decode("fs_pre", 1'b1, 32'h200, 32'h55555555);
        stall = 1'b1;
        offer(1'b1, 32'h204, 32'h66666666); step();
        check("fs_skid.ready", {31'd0, fetch_ready}, 32'd0);
        flush = 1'b1;
        offer(1'b1, 32'h208, 32'h77777777); step();
        check_decode("fs_flush", 1'b0, 32'h0, c_nop);
        check("fs_flush.ready", {31'd0, fetch_ready}, 32'd1);
        flush = 1'b0;
        stall = 1'b0;
        offer(1'b0, 32'h0, 32'h0); step();
        check_decode("fs_after", 1'b0, 32'h0, c_nop);
        step();
        check_decode("fs_after2", 1'b0, 32'h0, c_nop);

        // Back-to-back flushes reload the counter
        flush = 1'b1; step();
        check("rf_N.squash", {31'd0, squashing}, 32'd1);
        step();
        check("rf_N1.squash", {31'd0, squashing}, 32'd1);
        flush = 1'b0;
        offer(1'b1, 32'h300, 32'h88888888); step();
        check_decode("rf_N2", 1'b0, 32'h0, c_nop);
        check("rf_N2.squash", {31'd0, squashing}, 32'd0);
        offer(1'b1, 32'h304, 32'h99999999); step();
        check_decode("rf_N3", 1'b1, 32'h304, 32'h99999999);
        offer(1'b0, 32'h0, 32'h0); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
